sram_ecc_encoder: RTL

//  Write-side companion of the SRAM page ECC decoder. Accumulates the 8-bit page code over a page of
//  up to 8 16-bit words (batches 0..7) as they stream into SRAM, in the same code layout the read-side

---
 rtl/sram_ecc_encoder.sv | 102 ++++++++++
 1 files changed

// File: rtl/sram_ecc_encoder.sv
// sram_ecc_encoder: write-side page ECC generator.
// Folds each 16-bit word of a page (batches 0..7) into a running 8-bit
// parity accumulator using the read-side decoder's code layout. No data is
// buffered. The finished code is presented one cycle after the last word.
module sram_ecc_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [2:0]  in_batch,
  input  logic [15:0] data,
  input  logic        end_of_page,
  output logic [7:0]  code,
  output logic        code_valid,
  output logic        seq_err,
  output logic        busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

  // Contribution of one word to the page code. Global bit index is
  // g = 16*w + b; code[k] (k<7) covers the bits whose (g+1) has bit k set.
  // The last bit of the page (w=7, b=15) is kept out of [6:0] and is
  // carried raw in code[7].
  function automatic logic [7:0] word_contrib(input logic [2:0] w,
                                              input logic [15:0] d);
    logic [7:0] c;
    logic [7:0] gp1;
    c = 8'd0;
    for (int b = 0; b < 16; b++) begin
      gp1 = {1'b0, w, 4'(b)} + 8'd1;
      if (!((w == 3'd7) && (b == 15))) begin
        c[6:0] = c[6:0] ^ (gp1[6:0] & {7{d[b]}});
      end else begin
        c[6:0] = c[6:0];
      end
    end
    c[7] = (w == 3'd7) & d[15];
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [2:0]  exp_q, exp_d;
  logic [7:0]  code_q, code_d;
  logic        code_valid_q, code_valid_d;
  logic        seq_err_q, seq_err_d;
  logic [7:0]  contrib_s;

  // Next-state: fold accepted words, close pages, track expected batch index.
  always_comb begin
    contrib_s    = word_contrib(in_batch, data);
    state_d      = state_q;
    acc_d        = acc_q;
    exp_d        = exp_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    seq_err_d    = 1'b0;
    if (in_valid) begin
      seq_err_d = (in_batch != exp_q);
      if (end_of_page) begin
        // The closing word is folded directly into the output code, so
        // the accumulator can restart for a back-to-back page next cycle.
        code_d       = acc_q ^ contrib_s;
        code_valid_d = 1'b1;
        acc_d        = 8'd0;
        exp_d        = 3'd0;
        state_d      = ST_IDLE;
      end else begin
        acc_d   = acc_q ^ contrib_s;
        exp_d   = in_batch + 3'd1;
        state_d = ST_ACCUM;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset discards any partially built page.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_q        <= 8'd0;
      exp_q        <= 3'd0;
      code_q       <= 8'd0;
      code_valid_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      exp_q        <= exp_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign seq_err    = seq_err_q;
  assign busy       = (state_q == ST_ACCUM);

endmodule
